dma_engineer_arbiter: RTL and testbench

DMA_ENGINEER_ARBITER -- requirements
Module: dma_engineer_arbiter

---
 rtl/dma_engineer_arbiter.sv | 116 +++++++++++
 tb/tb_dma_engineer_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter that shares one DMA engine among N_REQ layer requesters.
// A granted requester owns the engine from request through its last data beat.
module dma_engineer_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 27,
    parameter int DATA_W = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           m_req,
    input  logic [N_REQ*ADDR_W-1:0]    m_start_addr,
    input  logic [N_REQ*ADDR_W-1:0]    m_length,
    output logic [N_REQ-1:0]           m_ack,
    output logic [N_REQ-1:0]           m_dout_en,
    output logic [N_REQ-1:0]           m_dout_eop,
    output logic [DATA_W-1:0]          m_dout,
    output logic                       dma_engineer_req,
    input  logic                       dma_engineer_ack,
    output logic [ADDR_W-1:0]          dma_engineer_start_addr,
    output logic [ADDR_W-1:0]          dma_engineer_length,
    input  logic                       dma_engineer_dout_en,
    input  logic                       dma_engineer_dout_eop,
    input  logic [DATA_W-1:0]          dma_engineer_dout,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int GID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [GID_W-1:0]    r_rr_ptr;
    logic [GID_W-1:0]    r_grant_id;
    logic [ADDR_W-1:0]   r_start_addr;
    logic [ADDR_W-1:0]   r_length;

    logic [2*N_REQ-1:0]  w_req_dbl;
    logic [N_REQ-1:0]    w_req_rot;
    logic                w_any;
    logic [GID_W-1:0]    w_winner;
    logic                w_last_beat;
    logic [N_REQ-1:0]    w_grant_oh;

    // Index arithmetic modulo N_REQ, which need not be a power of two.
    function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] base, input int off);
        logic [GID_W:0] sum;
        sum = {1'b0, base} + off[GID_W:0];
        if (sum >= (GID_W+1)'(N_REQ))
            sum = sum - (GID_W+1)'(N_REQ);
        return sum[GID_W-1:0];
    endfunction

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit then wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_req_dbl = {m_req, m_req} >> r_rr_ptr;
        w_req_rot = w_req_dbl[N_REQ-1:0];
        w_any     = |m_req;
        w_winner  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k])
                w_winner = wrap_add(r_rr_ptr, k);
        end
    end

    assign w_last_beat = dma_engineer_dout_en & dma_engineer_dout_eop;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = REQ;
            REQ:     if (dma_engineer_ack) w_next = XFER;
            XFER:    if (w_last_beat) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_start_addr <= '0;
            r_length     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant_id   <= w_winner;
                r_start_addr <= m_start_addr[w_winner*ADDR_W +: ADDR_W];
                r_length     <= m_length[w_winner*ADDR_W +: ADDR_W];
            end
            if (r_state == XFER && w_last_beat)
                r_rr_ptr <= wrap_add(r_grant_id, 1);
        end
    end

    // Outputs are forced low while rst is held, even before the reset edge lands.
    assign w_grant_oh              = N_REQ'(1) << r_grant_id;
    assign dma_engineer_req        = !rst && (r_state == REQ);
    assign busy                    = !rst && (r_state != IDLE);
    assign m_ack                   = (!rst && r_state == REQ && dma_engineer_ack) ? w_grant_oh : '0;
    assign m_dout_en               = (!rst && r_state == XFER && dma_engineer_dout_en) ? w_grant_oh : '0;
    assign m_dout_eop              = (!rst && r_state == XFER && w_last_beat) ? w_grant_oh : '0;
    assign m_dout                  = dma_engineer_dout;
    assign dma_engineer_start_addr = r_start_addr;
    assign dma_engineer_length     = r_length;
    assign grant_id                = r_grant_id;

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// Scoreboard bench for dma_engineer_arbiter: the stimulus process queues expected
// grants, acks and beats from a round-robin model; a negedge monitor compares them.
module tb_dma_engineer_arbiter;

    localparam int N  = 4;
    localparam int AW = 27;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_start_addr;
    logic [N*AW-1:0] m_length;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_dout_en;
    logic [N-1:0]    m_dout_eop;
    logic [DW-1:0]   m_dout;
    logic            dma_engineer_req;
    logic            dma_engineer_ack;
    logic [AW-1:0]   dma_engineer_start_addr;
    logic [AW-1:0]   dma_engineer_length;
    logic            dma_engineer_dout_en;
    logic            dma_engineer_dout_eop;
    logic [DW-1:0]   dma_engineer_dout;
    logic            busy;
    logic [1:0]      grant_id;

    dma_engineer_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .m_req                   (m_req),
        .m_start_addr            (m_start_addr),
        .m_length                (m_length),
        .m_ack                   (m_ack),
        .m_dout_en               (m_dout_en),
        .m_dout_eop              (m_dout_eop),
        .m_dout                  (m_dout),
        .dma_engineer_req        (dma_engineer_req),
        .dma_engineer_ack        (dma_engineer_ack),
        .dma_engineer_start_addr (dma_engineer_start_addr),
        .dma_engineer_length     (dma_engineer_length),
        .dma_engineer_dout_en    (dma_engineer_dout_en),
        .dma_engineer_dout_eop   (dma_engineer_dout_eop),
        .dma_engineer_dout       (dma_engineer_dout),
        .busy                    (busy),
        .grant_id                (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
    } grant_t;

    typedef struct {
        logic [N-1:0]  en;
        logic [N-1:0]  eop;
        logic [DW-1:0] data;
    } beat_t;

    grant_t       exp_grant_q[$];
    logic [N-1:0] exp_ack_q[$];
    beat_t        exp_beat_q[$];

    logic [AW-1:0] addr_m [N];
    logic [AW-1:0] len_m  [N];
    int            rr_m;
    int            mode;  // 0: acked requester drops, 1: all hold, 2: random
    int            checks = 0;
    int            errors = 0;

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic pack_bus();
        for (int i = 0; i < N; i++) begin
            m_start_addr[i*AW +: AW] = addr_m[i];
            m_length[i*AW +: AW]     = len_m[i];
        end
    endtask

    // Round robin: first requesting index at or after rr_m, wrapping.
    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr_m + k) % N;
            if (m_req[idx])
                return idx;
        end
        return -1;
    endfunction

    task automatic update_requesters(input int w);
        if (mode == 0) begin
            m_req[w] = 1'b0;
        end else if (mode == 2) begin
            if ($urandom_range(0, 1) == 1)
                m_req[w] = 1'b0;
            addr_m[w] = AW'($urandom);
            len_m[w]  = AW'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] && $urandom_range(0, 9) < 3) begin
                    m_req[i]  = 1'b1;
                    addr_m[i] = AW'($urandom);
                    len_m[i]  = AW'($urandom);
                end
            end
        end
        pack_bus();
    endtask

    // Called at posedge+1 with the DUT idle; plays the engine for one transaction.
    task automatic run_xfer(input int n_beats, input int rst_at);
        int     w;
        int     lat;
        grant_t g;
        beat_t  bt;
        w = model_winner();
        if (w < 0) begin
            check(1'b0, "no_request", DW'(m_req), 1);
            return;
        end
        g.id = w; g.addr = addr_m[w]; g.len = len_m[w];
        exp_grant_q.push_back(g);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!dma_engineer_req && lat < 8);
        check(dma_engineer_req && lat == 1, "req_latency", DW'(lat), 1);
        if (!dma_engineer_req)
            return;
        repeat ($urandom_range(0, 2)) begin
            dma_engineer_dout_en  = 1'b1;
            dma_engineer_dout_eop = 1'($urandom_range(0, 1));
            dma_engineer_dout     = rand_data();
            #1;
            check(m_dout_en == 0 && m_dout_eop == 0, "stray_en_in_req", DW'({m_dout_en, m_dout_eop}), 0);
            @(posedge clk); #1;
            dma_engineer_dout_en  = 1'b0;
            dma_engineer_dout_eop = 1'b0;
        end
        dma_engineer_ack = 1'b1;
        exp_ack_q.push_back(N'(1) << w);
        @(posedge clk); #1;
        dma_engineer_ack = 1'b0;
        update_requesters(w);
        for (int b = 0; b < n_beats; b++) begin
            repeat ($urandom_range(0, 1)) begin
                dma_engineer_dout_en  = 1'b0;
                dma_engineer_dout_eop = 1'($urandom_range(0, 1));
                dma_engineer_dout     = rand_data();
                @(posedge clk); #1;
            end
            dma_engineer_dout     = rand_data();
            dma_engineer_dout_en  = 1'b1;
            dma_engineer_dout_eop = (b == n_beats - 1);
            if (b == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check(busy == 1'b0, "busy_after_mid_rst", DW'(busy), 0);
                check(m_dout_en == 0, "en_after_mid_rst", DW'(m_dout_en), 0);
                check(grant_id == 0, "grant_id_after_mid_rst", DW'(grant_id), 0);
                for (int r = b + 1; r < n_beats; r++) begin
                    dma_engineer_dout_en  = 1'b1;
                    dma_engineer_dout_eop = (r == n_beats - 1);
                    dma_engineer_dout     = rand_data();
                    @(posedge clk); #1;
                end
                dma_engineer_dout_en  = 1'b0;
                dma_engineer_dout_eop = 1'b0;
                rr_m = 0;
                return;
            end
            bt.en   = N'(1) << w;
            bt.eop  = dma_engineer_dout_eop ? bt.en : '0;
            bt.data = dma_engineer_dout;
            exp_beat_q.push_back(bt);
            @(posedge clk); #1;
            dma_engineer_dout_en  = 1'b0;
            dma_engineer_dout_eop = 1'b0;
        end
        check(busy == 1'b0 && dma_engineer_req == 1'b0, "idle_after_eop", DW'({busy, dma_engineer_req}), 0);
        rr_m = (w + 1) % N;
    endtask

    task automatic do_reset();
        rst                   = 1'b1;
        m_req                 = '0;
        dma_engineer_ack      = 1'b1;
        dma_engineer_dout_en  = 1'b1;
        dma_engineer_dout_eop = 1'b1;
        dma_engineer_dout     = rand_data();
        pack_bus();
        @(posedge clk); #1;
        check(busy == 0 && dma_engineer_req == 0, "busy_req_in_rst", DW'({busy, dma_engineer_req}), 0);
        check(m_ack == 0 && m_dout_en == 0 && m_dout_eop == 0, "acks_in_rst", DW'({m_ack, m_dout_en, m_dout_eop}), 0);
        check(m_dout == dma_engineer_dout, "dout_passthru", m_dout, dma_engineer_dout);
        dma_engineer_ack      = 1'b0;
        dma_engineer_dout_en  = 1'b0;
        dma_engineer_dout_eop = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check(grant_id == 0 && dma_engineer_start_addr == 0 && dma_engineer_length == 0, "regs_after_rst",
              DW'({grant_id, dma_engineer_start_addr, dma_engineer_length}), 0);
        rr_m = 0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a grant, ack or beat.
    grant_t       mon_g;
    beat_t        mon_b;
    logic [N-1:0] mon_a;
    logic         prev_req = 1'b0;

    always @(negedge clk) begin
        if (dma_engineer_req && !prev_req) begin
            if (exp_grant_q.size() == 0) begin
                check(1'b0, "unexpected_grant", DW'(grant_id), 0);
            end else begin
                mon_g = exp_grant_q.pop_front();
                check(grant_id == mon_g.id, "grant_id", DW'(grant_id), DW'(mon_g.id));
                check(dma_engineer_start_addr == mon_g.addr, "start_addr", DW'(dma_engineer_start_addr), DW'(mon_g.addr));
                check(dma_engineer_length == mon_g.len, "length", DW'(dma_engineer_length), DW'(mon_g.len));
            end
        end
        if (m_ack != 0) begin
            if (exp_ack_q.size() == 0) begin
                check(1'b0, "unexpected_ack", DW'(m_ack), 0);
            end else begin
                mon_a = exp_ack_q.pop_front();
                check(m_ack == mon_a, "m_ack", DW'(m_ack), DW'(mon_a));
            end
        end
        if (m_dout_en != 0 || m_dout_eop != 0) begin
            if (exp_beat_q.size() == 0) begin
                check(1'b0, "unexpected_beat", DW'({m_dout_en, m_dout_eop}), 0);
            end else begin
                mon_b = exp_beat_q.pop_front();
                check(m_dout_en == mon_b.en && m_dout_eop == mon_b.eop, "beat_route",
                      DW'({m_dout_en, m_dout_eop}), DW'({mon_b.en, mon_b.eop}));
                check(m_dout == mon_b.data, "beat_data", m_dout, mon_b.data);
            end
        end
        prev_req <= dma_engineer_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_m[i] = '0;
            len_m[i]  = '0;
        end
        mode = 0;
        do_reset();

        // Single requester, long burst.
        addr_m[0] = 52; len_m[0] = 100;
        m_req = 4'b0001; pack_bus();
        run_xfer(100, -1);

        // rr_ptr is 1 now: requester 2 before requester 0.
        addr_m[0] = 27'h0123; len_m[0] = 27'h10;
        addr_m[2] = 27'h4567; len_m[2] = 27'h20;
        m_req = 4'b0101; pack_bus();
        run_xfer(2, -1);
        run_xfer(2, -1);

        // All requesters held high from reset: 0,1,2,3,0.
        do_reset();
        mode = 1;
        for (int i = 0; i < N; i++) begin
            addr_m[i] = AW'(1000 + 16 * i);
            len_m[i]  = 3;
        end
        m_req = 4'b1111; pack_bus();
        repeat (5) run_xfer(3, -1);
        m_req = '0; pack_bus();

        // Stray ack and beat while idle.
        dma_engineer_ack      = 1'b1;
        dma_engineer_dout_en  = 1'b1;
        dma_engineer_dout_eop = 1'b1;
        #1;
        check(m_ack == 0, "ack_in_idle", DW'(m_ack), 0);
        check(m_dout_en == 0 && m_dout_eop == 0, "en_in_idle", DW'({m_dout_en, m_dout_eop}), 0);
        @(posedge clk); #1;
        check(busy == 1'b0, "busy_after_idle_stray", DW'(busy), 0);
        dma_engineer_ack      = 1'b0;
        dma_engineer_dout_en  = 1'b0;
        dma_engineer_dout_eop = 1'b0;

        // Reset at beat 5 of 10, then requester 3 served normally.
        mode = 0;
        addr_m[1] = 27'h0abcd; len_m[1] = 10;
        m_req = 4'b0010; pack_bus();
        run_xfer(10, 5);
        addr_m[3] = 27'h7ff_0001; len_m[3] = 4;
        m_req = 4'b1000; pack_bus();
        run_xfer(4, -1);

        // Randomized traffic.
        mode = 2;
        repeat (150) begin
            if (m_req == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                m_req[i]  = 1'b1;
                addr_m[i] = AW'($urandom);
                len_m[i]  = AW'($urandom);
                pack_bus();
            end
            run_xfer($urandom_range(1, 4), -1);
        end
        m_req = '0; pack_bus();

        repeat (4) @(posedge clk);
        #1;
        check(exp_grant_q.size() == 0, "grant_q_drained", DW'(exp_grant_q.size()), 0);
        check(exp_ack_q.size() == 0, "ack_q_drained", DW'(exp_ack_q.size()), 0);
        check(exp_beat_q.size() == 0, "beat_q_drained", DW'(exp_beat_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
